// File: rtl/pifo_tree_driver_pkg.sv
// Shared types and widths for the PIFO tree driver slice.
package pifo_tree_driver_pkg;

    localparam int unsigned PTW = 16;
    localparam int unsigned MTW = 32;
    localparam int unsigned DW  = MTW + PTW;

    typedef logic [DW-1:0] pifo_word_t;

    typedef enum logic {
        ISSUE = 1'b0,
        GAP   = 1'b1
    } drv_state_t;

    typedef enum logic {
        RR_PUSH = 1'b0,
        RR_POP  = 1'b1
    } rr_t;

    // Priority field lives in the LSBs of a data word.
    function automatic logic [PTW-1:0] prio_of(pifo_word_t w);
        return w[PTW-1:0];
    endfunction

endpackage

// File: rtl/pifo_tree_driver_if.sv
// Enqueue, dequeue and tree-command bundle between classifier, consumer and PIFO tree.
interface pifo_tree_driver_if #(
    parameter int unsigned CTW = 10
);
    import pifo_tree_driver_pkg::*;

    logic             i_enq_valid;
    logic             o_enq_ready;
    pifo_word_t       i_enq_data;
    logic             i_deq_req;
    logic             o_deq_valid;
    logic             i_deq_ready;
    pifo_word_t       o_deq_data;
    logic             o_push;
    pifo_word_t       o_push_data;
    logic             o_pop;
    pifo_word_t       i_pop_data;
    logic [CTW-1:0]   o_count;
    logic             o_empty;
    logic             o_full;

    // Driver side.
    modport slave (
        input  i_enq_valid, i_enq_data, i_deq_req, i_deq_ready, i_pop_data,
        output o_enq_ready, o_deq_valid, o_deq_data, o_push, o_push_data,
        output o_pop, o_count, o_empty, o_full
    );

    // Environment side (classifier, consumer, tree).
    modport master (
        output i_enq_valid, i_enq_data, i_deq_req, i_deq_ready, i_pop_data,
        input  o_enq_ready, o_deq_valid, o_deq_data, o_push, o_push_data,
        input  o_pop, o_count, o_empty, o_full
    );

endinterface

// File: rtl/pifo_tree_driver_result_fifo.sv
// First-word-fall-through FIFO holding pop results until the consumer takes them.
module pifo_tree_driver_result_fifo
    import pifo_tree_driver_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_i,
    input  pifo_word_t    wdata_i,
    input  logic          rd_i,
    output pifo_word_t    rdata_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    pifo_word_t    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          rd_en;
    logic          wr_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rd_en   = rd_i && !empty_o;
    assign wr_en   = wr_i && (!full_o || rd_en);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    // Storage array, no reset needed.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + AW'(1);
            if (rd_en) rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/pifo_tree_driver.sv
// Spaces push/pop commands to the PIFO tree, tracks occupancy and buffers pop results.
module pifo_tree_driver
    import pifo_tree_driver_pkg::*;
#(
    parameter int unsigned CTW       = 10,
    parameter int unsigned CAPACITY  = 1023,
    parameter int unsigned OP_GAP    = 2,
    parameter int unsigned POP_LAT   = 1,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_arst_n,
    pifo_tree_driver_if.slave   bus
);

    localparam int unsigned GW       = (OP_GAP > 1) ? $clog2(OP_GAP) : 1;
    localparam int unsigned GAP_INIT = (OP_GAP > 1) ? OP_GAP - 2 : 0;
    localparam int unsigned IW       = $clog2(POP_LAT + 2);
    localparam int unsigned BCW      = $clog2(OUT_DEPTH) + 1;
    localparam int unsigned SW       = BCW + 1;

    drv_state_t         state_q;
    logic [GW-1:0]      gap_q;
    rr_t                rr_q;
    logic               push_q;
    logic               pop_q;
    pifo_word_t         push_data_q;
    logic [CTW-1:0]     count_q;
    logic [CTW-1:0]     count_d;
    logic               empty_q;
    logic               full_q;
    logic [POP_LAT-1:0] lat_q;
    logic [IW-1:0]      inflight_q;

    logic               push_el_c;
    logic               pop_el_c;
    logic               grant_push_c;
    logic               grant_pop_c;
    logic               credit_ok_c;
    logic [SW-1:0]      credit_sum_c;
    logic               pop_tail;
    logic [BCW-1:0]     buf_count;
    logic               buf_empty;
    logic               buf_full;
    logic               buf_rd;
    pifo_word_t         buf_rdata;

    assign pop_tail = lat_q[POP_LAT-1];
    assign buf_rd   = !buf_empty && bus.i_deq_ready;

    // Occupancy after the command currently on the tree bus lands.
    always_comb begin
        count_d = count_q;
        if (push_q) begin
            count_d = count_q + CTW'(1);
        end else if (pop_q) begin
            count_d = count_q - CTW'(1);
        end
    end

    // Eligibility and round-robin arbitration for the single command slot.
    always_comb begin
        credit_sum_c = SW'(inflight_q) + SW'(buf_count);
        credit_ok_c  = !buf_full && (credit_sum_c < SW'(OUT_DEPTH));
        push_el_c    = bus.i_enq_valid && (count_d != CTW'(CAPACITY)) && (state_q == ISSUE);
        pop_el_c     = bus.i_deq_req && (count_d != '0) && credit_ok_c && (state_q == ISSUE);
        grant_push_c = push_el_c && (!pop_el_c || (rr_q == RR_PUSH));
        grant_pop_c  = pop_el_c && !grant_push_c;
    end

    // Issue/gap sequencing between consecutive tree commands.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= ISSUE;
            gap_q   <= '0;
        end else begin
            case (state_q)
                ISSUE: begin
                    if ((grant_push_c || grant_pop_c) && (OP_GAP > 1)) begin
                        state_q <= GAP;
                        gap_q   <= GW'(GAP_INIT);
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_q <= ISSUE;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: state_q <= ISSUE;
            endcase
        end
    end

    // Registered tree commands, occupancy, arbiter pointer and pop latency tracking.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            rr_q        <= RR_PUSH;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            push_data_q <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            lat_q       <= '0;
            inflight_q  <= '0;
        end else begin
            push_q     <= grant_push_c;
            pop_q      <= grant_pop_c;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == CTW'(CAPACITY));
            lat_q      <= POP_LAT'({lat_q, pop_q});
            inflight_q <= inflight_q + IW'(grant_pop_c) - IW'(pop_tail);
            if (grant_push_c) begin
                push_data_q <= bus.i_enq_data;
                rr_q        <= RR_POP;
            end else if (grant_pop_c) begin
                rr_q        <= RR_PUSH;
            end
        end
    end

    pifo_tree_driver_result_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_result_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_arst_n),
        .wr_i    (pop_tail),
        .wdata_i (bus.i_pop_data),
        .rd_i    (buf_rd),
        .rdata_o (buf_rdata),
        .count_o (buf_count),
        .empty_o (buf_empty),
        .full_o  (buf_full)
    );

    assign bus.o_enq_ready = grant_push_c;
    assign bus.o_push      = push_q;
    assign bus.o_push_data = push_data_q;
    assign bus.o_pop       = pop_q;
    assign bus.o_count     = count_q;
    assign bus.o_empty     = empty_q;
    assign bus.o_full      = full_q;
    assign bus.o_deq_valid = !buf_empty;
    assign bus.o_deq_data  = buf_rdata;

endmodule

// File: tb/tb_pifo_tree_driver.sv
// Randomized and directed bench for pifo_tree_driver with a behavioural tree/driver model.
module tb_pifo_tree_driver;
    import pifo_tree_driver_pkg::*;

    localparam int CAP     = 1023;
    localparam int OP_GAP  = 2;
    localparam int POP_LAT = 1;
    localparam int DEPTH   = 4;

    logic clk;
    logic rst_n;

    pifo_tree_driver_if #(.CTW(10)) bus();

    pifo_tree_driver #(
        .CTW       (10),
        .CAPACITY  (CAP),
        .OP_GAP    (OP_GAP),
        .POP_LAT   (POP_LAT),
        .OUT_DEPTH (DEPTH)
    ) dut (
        .i_clk    (clk),
        .i_arst_n (rst_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total;
    int bad;
    int k;

    // Model state: tree contents, pops awaiting return, result buffer.
    pifo_word_t tree_q[$];
    pifo_word_t pend_w[$];
    int         pend_due[$];
    pifo_word_t buf_q[$];
    bit         exp_push;
    bit         exp_pop;
    pifo_word_t exp_push_data;
    bit         pref_push;
    int         last_grant;

    // Stimulus state and logs.
    pifo_word_t enq_q[$];
    int         deq_reqs;
    int         ready_mode;
    bit         rand_traffic;
    int         push_cyc[$];
    int         cmd_log[$];
    bit         rdy_log[$];
    pifo_word_t deq_log[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, k);
        end
    endtask

    function automatic pifo_word_t mkw(int unsigned meta, int unsigned prio);
        return {32'(meta), 16'(prio)};
    endfunction

    // Tree behaviour: smallest priority leaves first, oldest first among equals.
    function automatic pifo_word_t tree_pop_min();
        int best;
        pifo_word_t w;
        if (tree_q.size() == 0) return '0;
        best = 0;
        for (int i = 1; i < tree_q.size(); i++) begin
            if (prio_of(tree_q[i]) < prio_of(tree_q[best])) best = i;
        end
        w = tree_q[best];
        tree_q.delete(best);
        return w;
    endfunction

    task automatic model_clear();
        tree_q.delete();
        pend_w.delete();
        pend_due.delete();
        buf_q.delete();
        enq_q.delete();
        exp_push   = 1'b0;
        exp_pop    = 1'b0;
        pref_push  = 1'b1;
        last_grant = k - 100;
        deq_reqs   = 0;
    endtask

    // One cycle: compare against the model, update it, drive the next inputs.
    task automatic step();
        bit allowed;
        bit push_el;
        bit pop_el;
        bit gp;
        bit gpop;
        @(negedge clk);
        k++;
        if (!rst_n) begin
            model_clear();
            bus.i_enq_valid = 1'b0;
            bus.i_deq_req   = 1'b0;
            bus.i_deq_ready = 1'b0;
            bus.i_enq_data  = '0;
            bus.i_pop_data  = {32'($urandom), 16'($urandom)};
            return;
        end
        while (pend_due.size() > 0 && pend_due[0] < k) begin
            buf_q.push_back(pend_w.pop_front());
            void'(pend_due.pop_front());
        end
        chk("deq_valid", bus.o_deq_valid, buf_q.size() > 0);
        if (buf_q.size() > 0) chk("deq_data", bus.o_deq_data, buf_q[0]);
        chk("count", bus.o_count, tree_q.size());
        chk("empty", bus.o_empty, tree_q.size() == 0);
        chk("full", bus.o_full, tree_q.size() == CAP);
        chk("push", bus.o_push, exp_push);
        chk("pop", bus.o_pop, exp_pop);
        if (bus.o_push && exp_push) chk("push_data", bus.o_push_data, exp_push_data);
        if (bus.o_push) begin
            tree_q.push_back(bus.o_push_data);
            last_grant = k - 1;
            push_cyc.push_back(k);
            cmd_log.push_back(0);
        end
        if (bus.o_pop) begin
            pend_w.push_back(tree_pop_min());
            pend_due.push_back(k + POP_LAT);
            last_grant = k - 1;
            cmd_log.push_back(1);
            if (deq_reqs > 0) deq_reqs--;
        end
        if (pend_due.size() > 0 && pend_due[0] == k) bus.i_pop_data = pend_w[0];
        else bus.i_pop_data = {32'($urandom), 16'($urandom)};
        case (ready_mode)
            0:       bus.i_deq_ready = 1'b0;
            1:       bus.i_deq_ready = 1'b1;
            default: bus.i_deq_ready = 1'($urandom_range(0, 1));
        endcase
        if (rand_traffic) begin
            if (enq_q.size() == 0 && $urandom_range(0, 2) == 0)
                enq_q.push_back({32'($urandom), 16'($urandom_range(0, 63))});
            if ($urandom_range(0, 3) == 0 && deq_reqs < 3) deq_reqs++;
        end
        bus.i_enq_valid = enq_q.size() > 0;
        bus.i_enq_data  = (enq_q.size() > 0) ? enq_q[0] : {32'($urandom), 16'($urandom)};
        bus.i_deq_req   = deq_reqs > 0;
        allowed = (k >= last_grant + OP_GAP);
        push_el = bus.i_enq_valid && tree_q.size() < CAP && allowed;
        pop_el  = bus.i_deq_req && tree_q.size() > 0 &&
                  (pend_w.size() + buf_q.size() < DEPTH) && allowed;
        gp   = push_el && (!pop_el || pref_push);
        gpop = pop_el && !gp;
        #1;
        chk("enq_ready", bus.o_enq_ready, gp);
        rdy_log.push_back(bus.o_enq_ready);
        if (gp) begin
            exp_push_data = enq_q.pop_front();
            pref_push     = 1'b0;
        end
        if (gpop) pref_push = 1'b1;
        exp_push = gp;
        exp_pop  = gpop;
        if (buf_q.size() > 0 && bus.i_deq_ready) deq_log.push_back(buf_q.pop_front());
    endtask

    initial begin
        int k0;
        int n;
        int pops;
        total = 0;
        bad   = 0;
        k     = 0;
        ready_mode   = 1;
        rand_traffic = 1'b0;
        rst_n = 1'b0;
        bus.i_enq_valid = 1'b0;
        bus.i_enq_data  = '0;
        bus.i_deq_req   = 1'b0;
        bus.i_deq_ready = 1'b0;
        bus.i_pop_data  = '0;
        model_clear();
        repeat (3) step();
        chk("rst_empty", bus.o_empty, 1);
        chk("rst_count", bus.o_count, 0);
        chk("rst_push", bus.o_push, 0);
        chk("rst_deq_valid", bus.o_deq_valid, 0);
        rst_n = 1'b1;
        step();

        // Three back-to-back enqueues: pushes two cycles apart.
        push_cyc.delete();
        rdy_log.delete();
        enq_q.push_back(mkw(32'h100, 5));
        enq_q.push_back(mkw(32'h200, 3));
        enq_q.push_back(mkw(32'h300, 9));
        k0 = k + 1;
        repeat (10) step();
        chk("t1_npush", push_cyc.size(), 3);
        if (push_cyc.size() == 3) begin
            chk("t1_push0", push_cyc[0], k0 + 1);
            chk("t1_push1", push_cyc[1], k0 + 3);
            chk("t1_push2", push_cyc[2], k0 + 5);
        end
        chk("t1_rdy", {rdy_log[0], rdy_log[1], rdy_log[2], rdy_log[3], rdy_log[4]}, 5'b10101);
        chk("t1_count", bus.o_count, 3);

        // Three pops come back in priority order.
        deq_log.delete();
        deq_reqs = 3;
        repeat (20) step();
        chk("t2_n", deq_log.size(), 3);
        if (deq_log.size() == 3) begin
            chk("t2_p0", prio_of(deq_log[0]), 3);
            chk("t2_p1", prio_of(deq_log[1]), 5);
            chk("t2_p2", prio_of(deq_log[2]), 9);
            chk("t2_m0", deq_log[0], mkw(32'h200, 3));
        end
        chk("t2_empty", bus.o_empty, 1);

        // Push and pop pressure together: commands alternate.
        enq_q.push_back(mkw(1, 7));
        repeat (4) step();
        cmd_log.delete();
        for (int i = 0; i < 4; i++) enq_q.push_back(mkw(i, 20 + i));
        deq_reqs = 3;
        repeat (20) step();
        chk("t3_n", cmd_log.size(), 7);
        if (cmd_log.size() >= 6)
            chk("t3_seq", {cmd_log[0][0], cmd_log[1][0], cmd_log[2][0],
                           cmd_log[3][0], cmd_log[4][0], cmd_log[5][0]}, 6'b101010);

        // Fill to capacity, hold one extra element, free one slot.
        n = CAP - tree_q.size() + 1;
        for (int i = 0; i < n; i++) enq_q.push_back({32'($urandom), 16'($urandom_range(0, 999))});
        n = 0;
        while (!bus.o_full && n < 3 * CAP) begin step(); n++; end
        chk("t4_full_reached", bus.o_full, 1);
        repeat (6) step();
        chk("t4_full", bus.o_full, 1);
        chk("t4_count", bus.o_count, CAP);
        chk("t4_valid_held", bus.i_enq_valid, 1);
        chk("t4_ready_low", bus.o_enq_ready, 0);
        deq_reqs = 1;
        repeat (12) step();
        chk("t4_refill", bus.o_count, CAP);
        chk("t4_left", enq_q.size(), 0);
        deq_reqs = CAP;
        n = 0;
        while ((tree_q.size() > 0 || buf_q.size() > 0 || pend_w.size() > 0) && n < 3 * CAP) begin
            step(); n++;
        end
        chk("t4_drained", bus.o_empty, 1);
        deq_reqs = 0;

        // Consumer stalled: credit limits pops to the buffer depth.
        ready_mode = 0;
        for (int i = 0; i < 10; i++) enq_q.push_back(mkw(i, 100 - i));
        repeat (25) step();
        cmd_log.delete();
        deq_log.delete();
        deq_reqs = 10;
        repeat (40) step();
        pops = 0;
        foreach (cmd_log[i]) if (cmd_log[i] == 1) pops++;
        chk("t5_pops_stalled", pops, 4);
        chk("t5_valid", bus.o_deq_valid, 1);
        ready_mode = 1;
        repeat (60) step();
        chk("t5_delivered", deq_log.size(), 10);
        chk("t5_count", bus.o_count, 0);

        // Reset with a pop in flight.
        enq_q.push_back(mkw(9, 1));
        enq_q.push_back(mkw(9, 2));
        repeat (8) step();
        cmd_log.delete();
        deq_reqs = 1;
        n = 0;
        while (cmd_log.size() == 0 && n < 10) begin step(); n++; end
        chk("t6_pop_seen", cmd_log.size(), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_pop", bus.o_pop, 0);
        chk("t6_push", bus.o_push, 0);
        chk("t6_count", bus.o_count, 0);
        chk("t6_empty", bus.o_empty, 1);
        chk("t6_full", bus.o_full, 0);
        chk("t6_push_data", bus.o_push_data, 0);
        chk("t6_deq_valid", bus.o_deq_valid, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) begin
            step();
            chk("t6_stale", bus.o_deq_valid, 0);
        end

        // Random traffic with a random consumer, then drain.
        ready_mode   = 2;
        rand_traffic = 1'b1;
        repeat (4000) step();
        rand_traffic = 1'b0;
        ready_mode   = 1;
        n = 0;
        while ((enq_q.size() > 0 || tree_q.size() > 0 || buf_q.size() > 0 || pend_w.size() > 0)
               && n < 4000) begin
            deq_reqs = tree_q.size() + 1;
            step(); n++;
        end
        deq_reqs = 0;
        repeat (4) step();
        chk("final_empty", bus.o_empty, 1);
        chk("final_deq_valid", bus.o_deq_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
